beam_cfg_serializer: RTL

//  Downstream stage of the sequencer: takes the 16-bit beam configuration word it produces and

---
 rtl/beam_cfg_pkg.sv | 14 +
 rtl/sclk_tick_gen.sv | 30 +++
 rtl/beam_cfg_serializer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/beam_cfg_pkg.sv
// Shared types and defaults for the beam configuration serializer.
// FSM state encoding and default frame width / SCLK divider.
package beam_cfg_pkg;

  localparam int CFG_WIDTH = 16;
  localparam int SCLK_DIV  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

endpackage

// File: rtl/sclk_tick_gen.sv
// Divider: tick every CLK_DIV cycles while en=1, held cleared while en=0.
// Ports: clk, rst (sync, active high), en, tick (combinational pulse).
module sclk_tick_gen
  import beam_cfg_pkg::*;
#(
  parameter int CLK_DIV = SCLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] TC = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en)
      cnt <= '0;
    else if (cnt == TC)
      cnt <= '0;
    else
      cnt <= cnt + DW'(1);
  end

  assign tick = en && (cnt == TC);

endmodule

// File: rtl/beam_cfg_serializer.sv
// Shifts a config word out as SCLK/SDATA, then pulses LE (sle) and done.
// Ports: clk, rst, cfg_word, cfg_load, auto_en -> ready, sclk, sdata, sle, done, cfg_drop.
module beam_cfg_serializer
  import beam_cfg_pkg::*;
#(
  parameter int WIDTH        = CFG_WIDTH,
  parameter int CLK_DIV      = SCLK_DIV,
  parameter int LATCH_CYCLES = 2,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cfg_word,
  input  logic             cfg_load,
  input  logic             auto_en,
  output logic             ready,
  output logic             sclk,
  output logic             sdata,
  output logic             sle,
  output logic             done,
  output logic             cfg_drop
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_TC = BW'(WIDTH);
  localparam logic [LW-1:0] LAT_TC = LW'(LATCH_CYCLES - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [WIDTH-1:0] last_sent, last_n;
  logic [WIDTH-1:0] shifted;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [LW-1:0]    lcnt, lcnt_n;
  logic             sclk_n, sdata_n, sle_n;
  logic             done_n, ready_n, drop_n;
  logic             start, tick;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state == SHIFT),
    .tick (tick)
  );

  assign start   = cfg_load || (auto_en && (cfg_word != last_sent));
  assign shifted = MSB_FIRST ? (sreg << 1) : (sreg >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      last_sent <= '0;
      bit_cnt   <= '0;
      lcnt      <= '0;
      ready     <= 1'b1;
      sclk      <= 1'b0;
      sdata     <= 1'b0;
      sle       <= 1'b0;
      done      <= 1'b0;
      cfg_drop  <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      last_sent <= last_n;
      bit_cnt   <= bit_n;
      lcnt      <= lcnt_n;
      ready     <= ready_n;
      sclk      <= sclk_n;
      sdata     <= sdata_n;
      sle       <= sle_n;
      done      <= done_n;
      cfg_drop  <= drop_n;
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    last_n  = last_sent;
    bit_n   = bit_cnt;
    lcnt_n  = lcnt;
    ready_n = ready;
    sclk_n  = sclk;
    sdata_n = sdata;
    sle_n   = sle;
    done_n  = 1'b0;
    // Auto-mode word changes while busy are not drops; they
    // are re-evaluated against last_sent once back in IDLE.
    drop_n  = cfg_load && (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) begin
          sreg_n  = cfg_word;
          last_n  = cfg_word;
          sdata_n = head(cfg_word);
          sclk_n  = 1'b0;
          bit_n   = '0;
          ready_n = 1'b0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          unique case (1'b1)
            !sclk: begin
              sclk_n = 1'b1;
              bit_n  = bit_cnt + BW'(1);
            end
            sclk && (bit_cnt == BIT_TC): begin
              sclk_n  = 1'b0;
              sdata_n = 1'b0;
              sle_n   = 1'b1;
              lcnt_n  = '0;
              state_n = LATCH;
            end
            default: begin
              sclk_n  = 1'b0;
              sreg_n  = shifted;
              sdata_n = head(shifted);
            end
          endcase
        end
      end
      LATCH: begin
        if (lcnt == LAT_TC) begin
          sle_n   = 1'b0;
          done_n  = 1'b1;
          ready_n = 1'b1;
          state_n = IDLE;
        end else begin
          lcnt_n = lcnt + LW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
